// File: rtl/alu_ctrl_md_pkg.sv
// Shared constants for the execute-stage ALU control decoder and its
// iterative RV32M multiply/divide engine.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_ARITH = 2'b10;
    localparam logic [1:0] AOP_PASS  = 2'b11;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Execute-stage bundle between the pipeline and the ALU control / M-op engine.
interface alu_ctrl_md_if #(parameter int XLEN = 32);

    logic            Valid;
    logic            Is_R;
    logic [6:0]      Funct_7;
    logic [2:0]      Funct_3;
    logic [1:0]      ALU_Op;
    logic [XLEN-1:0] Op_A;
    logic [XLEN-1:0] Op_B;
    logic            Flush;
    logic [3:0]      ALU_Sel;
    logic            MD_Sel;
    logic [XLEN-1:0] MD_Result;
    logic            MD_Done;
    logic            Stall;

    modport master (
        output Valid, Is_R, Funct_7, Funct_3, ALU_Op, Op_A, Op_B, Flush,
        input  ALU_Sel, MD_Sel, MD_Result, MD_Done, Stall
    );

    modport slave (
        input  Valid, Is_R, Funct_7, Funct_3, ALU_Op, Op_A, Op_B, Flush,
        output ALU_Sel, MD_Sel, MD_Result, MD_Done, Stall
    );

endinterface

// File: rtl/alu_ctrl_md_iter_core.sv
// Bit-serial multiply (shift-add) / divide (restoring) datapath on operand
// magnitudes, with sign fix-up folded into the final iteration.
module md_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result,
    output logic            done
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   hi, lo, opnd;
    logic [2:0]        op_q;
    logic              neg_q;

    logic              a_neg, b_neg, neg_start;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;
    logic              div_zero, div_ovf;

    logic [XLEN:0]     add_sum, shifted, diff;
    logic [XLEN-1:0]   hi_nxt, lo_nxt, dv, fin;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        a_neg     = op_a_signed(op) && a[XLEN-1];
        b_neg     = op_b_signed(op) && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_start = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = (b == '0);
        div_ovf   = op_b_signed(op) && (a == SMIN) && (b == ONES);
        special   = op[2] && (div_zero || div_ovf);
        if (div_zero) special_val = op[1] ? a : ONES;
        else          special_val = op[1] ? '0 : a;
    end

    assign last = (cnt == '0);

    // hi/lo hold {partial product, multiplier} or {remainder, dividend->quotient}.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = add_sum[XLEN:1];
            lo_nxt = {add_sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_nxt, lo_nxt};
        prod_s = neg_q ? -prod : prod;
        dv     = op_q[1] ? hi_nxt : lo_nxt;
        if (op_q[2])                fin = neg_q ? -dv : dv;
        else if (op_q[1:0] == 2'b00) fin = prod_s[XLEN-1:0];
        else                         fin = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt   <= CW'(XLEN-1);
                op_q  <= op;
                neg_q <= neg_start;
                hi    <= '0;
                lo    <= op[2] ? a_mag : b_mag;
                opnd  <= op[2] ? b_mag : a_mag;
                if (special) begin
                    result <= special_val;
                    done   <= 1'b1;
                end
            end else if (run && !kill) begin
                hi <= hi_nxt;
                lo <= lo_nxt;
                if (last) begin
                    result <= fin;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// Execute-stage ALU_Sel decoder plus the FSM sequencing the RV32M engine;
// base ops decode combinationally, M ops stall until MD_Done.
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_ctrl_md_if.slave bus
);

    md_state_e       state, state_nxt;
    logic            is_md, req, start, run, stall;
    logic            special, last, done;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] result;

    assign is_md = MD_EN && (bus.ALU_Op == AOP_ARITH) && bus.Is_R && (bus.Funct_7 == F7_MULDIV);
    assign req   = bus.Valid && is_md && !bus.Flush;

    always_comb begin
        alu_sel = ALU_ADD;
        case (bus.ALU_Op)
            AOP_ADD:  alu_sel = ALU_ADD;
            AOP_SUB:  alu_sel = ALU_SUB;
            AOP_PASS: alu_sel = ALU_PASS;
            default: begin
                case (bus.Funct_3)
                    // ADDI immediates may carry bit 30 set; only R-type can SUB.
                    3'b000:  alu_sel = (bus.Is_R && bus.Funct_7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_sel = ALU_SLL;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b011:  alu_sel = ALU_SLTU;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b101:  alu_sel = bus.Funct_7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_sel = ALU_OR;
                    default: alu_sel = ALU_AND;
                endcase
            end
        endcase
        if (is_md) alu_sel = ALU_PASS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (special)            state_nxt = ST_DONE;
                    else if (bus.Funct_3[2]) state_nxt = ST_DIV;
                    else                    state_nxt = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.Flush) state_nxt = ST_IDLE;
                else if (last) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start = (state == ST_IDLE) && req;
        run   = (state == ST_MUL) || (state == ST_DIV);
        stall = start || run;
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (bus.Flush),
        .run     (run),
        .op      (bus.Funct_3),
        .a       (bus.Op_A),
        .b       (bus.Op_B),
        .special (special),
        .last    (last),
        .result  (result),
        .done    (done)
    );

    assign bus.ALU_Sel   = alu_sel;
    assign bus.MD_Sel    = is_md;
    assign bus.MD_Result = result;
    assign bus.MD_Done   = done;
    assign bus.Stall     = stall;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench: base decode sweep, M-op results/latency via a result queue,
// flush and asynchronous reset mid-operation.
module tb_alu_ctrl_md;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_md_if #(.XLEN(XLEN)) bus();

    alu_ctrl_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [1:0] aop, input logic isr,
                           input logic [6:0] f7, input logic [2:0] f3,
                           input logic [3:0] exp_sel, input logic exp_md);
        bus.Valid = 1'b0; bus.ALU_Op = aop; bus.Is_R = isr;
        bus.Funct_7 = f7; bus.Funct_3 = f3;
        #1;
        check({tag, "/alu_sel"}, bus.ALU_Sel, exp_sel);
        check({tag, "/md_sel"}, bus.MD_Sel, exp_md);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.Valid = 1'b1; bus.Is_R = 1'b1; bus.ALU_Op = 2'b10;
        bus.Funct_7 = 7'b0000001; bus.Funct_3 = f3;
        bus.Op_A = a; bus.Op_B = b; bus.Flush = 1'b0;
    endtask

    // Called just after a rising edge; the op is accepted at the next edge.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc = 0;
        int stalls = 1;
        logic [31:0] e;
        exp_q.push_back(exp);
        issue(f3, a, b);
        #1;
        check({tag, "/stall0"}, bus.Stall, 1);
        check({tag, "/md_sel"}, bus.MD_Sel, 1);
        check({tag, "/alu_pass"}, bus.ALU_Sel, 4'b0011);
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!bus.MD_Done && bus.Stall) stalls++;
        end while (!bus.MD_Done && cyc < exp_cyc + 5);
        check({tag, "/done"}, bus.MD_Done, 1);
        check({tag, "/done_cyc"}, cyc, exp_cyc);
        check({tag, "/stall_cnt"}, stalls, exp_cyc);
        check({tag, "/stall_done"}, bus.Stall, 0);
        e = exp_q.pop_front();
        check({tag, "/result"}, bus.MD_Result, e);
        // Valid is still high through DONE; the FSM must not relaunch.
        @(posedge clk);
        bus.Valid = 1'b0;
        #1;
        check({tag, "/no_restart"}, bus.Stall, 0);
        check({tag, "/done_pulse"}, bus.MD_Done, 0);
        check({tag, "/held"}, bus.MD_Result, e);
    endtask

    initial begin
        int done_seen;
        bus.Valid = 1'b0; bus.Is_R = 1'b0; bus.Funct_7 = '0; bus.Funct_3 = '0;
        bus.ALU_Op = 2'b00; bus.Op_A = '0; bus.Op_B = '0; bus.Flush = 1'b0;

        #12;
        check("rst/done", bus.MD_Done, 0);
        check("rst/result", bus.MD_Result, 0);
        check("rst/stall", bus.Stall, 0);
        @(negedge clk) rst = 1'b0;

        chk_dec("addi_b30", 2'b10, 1'b0, 7'b0100000, 3'b000, 4'b0000, 1'b0);
        chk_dec("sub",      2'b10, 1'b1, 7'b0100000, 3'b000, 4'b0001, 1'b0);
        chk_dec("srai",     2'b10, 1'b0, 7'b0100000, 3'b101, 4'b1010, 1'b0);
        chk_dec("sra",      2'b10, 1'b1, 7'b0100000, 3'b101, 4'b1010, 1'b0);
        chk_dec("srl",      2'b10, 1'b1, 7'b0000000, 3'b101, 4'b1000, 1'b0);
        chk_dec("sltu",     2'b10, 1'b1, 7'b0000000, 3'b011, 4'b1111, 1'b0);
        chk_dec("aop_add",  2'b00, 1'b1, 7'b0000001, 3'b000, 4'b0000, 1'b0);
        chk_dec("aop_sub",  2'b01, 1'b0, 7'b0000000, 3'b000, 4'b0001, 1'b0);
        chk_dec("aop_pass", 2'b11, 1'b0, 7'b0000000, 3'b000, 4'b0011, 1'b0);
        chk_dec("i_f7_m",   2'b10, 1'b0, 7'b0000001, 3'b110, 4'b0100, 1'b0);
        chk_dec("md_dec",   2'b10, 1'b1, 7'b0000001, 3'b111, 4'b0011, 1'b1);

        @(posedge clk); #1;
        run_md("mul",    3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_md("mulh",   3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_md("mulhu",  3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
        run_md("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_md("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_md("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_md("remu",   3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_md("div0",   3'b100, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1);
        run_md("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_md("rem0",   3'b110, 32'd5, 32'd0, 32'd5, 1);

        // Flush in cycle 10 of a MUL.
        issue(3'b000, 32'd9, 32'd11);
        repeat (10) @(posedge clk);
        #1;
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        bus.Valid = 1'b0;
        #1;
        check("flush/stall", bus.Stall, 0);
        check("flush/done", bus.MD_Done, 0);
        check("flush/result", bus.MD_Result, 32'd5);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.MD_Done) done_seen++;
        end
        check("flush/no_done", done_seen, 0);
        run_md("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset between edges in the middle of a DIV.
        issue(3'b100, 32'hFFFFFFF9, 32'd2);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.Valid = 1'b0;
        #1;
        check("arst/stall", bus.Stall, 0);
        check("arst/done", bus.MD_Done, 0);
        check("arst/result", bus.MD_Result, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_md("post_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_md.md
# alu_ctrl_md

Parametrised successor to the single-cycle ALU control decoder. It decodes ALU_Sel for the base RV32I integer datapath and also owns an iterative multiply/divide engine for the RV32M instructions. While an M-extension operation is in progress, the engine stalls the pipeline. The block sits in the execute stage beside the ALU: base ops complete combinationally, and M ops return their result through MD_Result and MD_Done.

## Interface
- XLEN, 32: operand and result width.
- MD_EN, 1: 1 enables RV32M decode; 0 decodes Funct_7 = 0000001 encodings as base ops and never stalls.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- Valid  in  1  execute-stage instruction valid.
- Is_R  in  1  instruction is R-type (opcode bit 5); 0 means I-type ALU op.
- Funct_7  in  7  instruction funct7 field.
- Funct_3  in  3  instruction funct3 field.
- ALU_Op  in  2  main-control class: 00 add, 01 branch-sub, 10 R/I arith, 11 pass (LUI).
- Op_A, Op_B  in  XLEN  rs1 / rs2 operands, used only by M ops.
- Flush  in  1  kill the current execute instruction.
- ALU_Sel  out  4  base ALU select.
- MD_Sel  out  1  writeback takes MD_Result instead of the ALU result.
- MD_Result  out  XLEN  M-op result; valid when MD_Done = 1.
- MD_Done  out  1  one-cycle completion pulse.
- Stall  out  1  hold the pipeline.

## Operation
- ALU_Sel encodings, unchanged from the previous generation:
  - ADD 0000, SUB 0001, PASS 0011, OR 0100, AND 0101, XOR 0111
  - SRL 1000, SLL 1001, SRA 1010, SLT 1101, SLTU 1111
- ALU_Op 00 gives ADD, 01 gives SUB, 11 gives PASS.
- For ALU_Op 10, Funct_3 selects the op as before, with two fixes:
  - SUB only when Is_R && Funct_7[5]. I-type ADDI always gives ADD, whatever its immediate bits.
  - SRA vs SRL is selected by Funct_7[5] for both R-type and I-type.
- M op detection: is_md = MD_EN && ALU_Op == 10 && Is_R && Funct_7 == 0000001.
  - MD_Sel = is_md, combinational.
  - ALU_Sel = PASS when is_md.
- Funct_3 decode for M ops:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on Valid && is_md && !Flush:
  - latch operand magnitudes, result-sign flags and the op;
  - load the iteration counter with XLEN-1;
  - go to MUL (Funct_3[2] = 0) or DIV (Funct_3[2] = 1).
- MUL: shift-add, one bit per cycle, 2·XLEN-bit accumulator. When the counter reaches 0, go to DONE.
- DIV: restoring divide, one quotient bit per cycle. When the counter reaches 0, go to DONE.
- DONE: the final sign correction is already applied.
  - MD_Done = 1, MD_Result is held.
  - Next state is IDLE unconditionally. The same Valid never restarts a new op from DONE.
- Result selection:
  - MUL takes the low XLEN bits of the product.
  - MULH, MULHSU and MULHU take the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
- Special cases, decided in IDLE. These skip the iterations and go straight to DONE:
  - divide by zero: DIV/DIVU give all-ones; REM/REMU give Op_A.
  - signed overflow (Op_A = 1 followed by zeros, Op_B = all-ones) on DIV/REM: DIV gives Op_A, REM gives 0.
- Flush in any state forces IDLE on the next edge. MD_Done is not raised, and MD_Result keeps its last value.
- Reset (asynchronous, any state, including mid-operation):
  - state IDLE, counter 0, MD_Result 0, MD_Done 0;
  - Stall and MD_Sel follow their combinational equations (Stall 0 unless a new request is present).

## Timing
- ALU_Sel and MD_Sel: purely combinational, zero latency.
- Stall = (IDLE && Valid && is_md && !Flush) || MUL || DIV. Stall is 0 in DONE, so the pipeline advances in the MD_Done cycle.
- Normal M op accepted at edge cycle 0: MUL/DIV occupies cycles 1..XLEN, and DONE is at cycle XLEN+1.
  - Stall is high for XLEN+1 cycles (cycles 0..XLEN).
  - MD_Done pulses at cycle XLEN+1.
- Special-case divide: Stall is high in cycle 0 only, and MD_Done pulses in cycle 1.
- MD_Result and MD_Done are registered outputs.
- Back-to-back M ops: the second is accepted in the cycle after DONE, when the FSM is in IDLE again.

## Structure
- Package alu_ctrl_pkg holds:
  - ALU_Sel localparams (ALU_ADD … ALU_SLTU);
  - ALU_Op class constants;
  - M-op Funct_3 constants;
  - FSM state encoding.
- Sub-module md_iter_core holds the iteration datapath: counter, accumulator/remainder registers and sign fix-up, with a start/op/done interface.
- The top level keeps the decode and the FSM.

## Test plan
- Base decode sweep:
  - ALU_Op = 10, Is_R = 0, Funct_3 = 000, Funct_7 = 0100000 → ALU_Sel = 0000 (ADDI). The same with Is_R = 1 → 0001.
  - Funct_3 = 101, Funct_7[5] = 1 → 1010 for both Is_R values.
- MUL with XLEN = 32: Op_A = 7, Op_B = 0xFFFFFFFD.
  - Stall high for 33 cycles.
  - MD_Done at cycle 33 with MD_Result = 0xFFFFFFEB.
  - MULH with the same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- DIV: Op_A = 0xFFFFFFF9 (−7), Op_B = 2.
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
- Special cases:
  - DIV x/0 → 0xFFFFFFFF; REM 5/0 → 5. Both give MD_Done at cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush at cycle 10 of a MUL:
  - IDLE next cycle, Stall drops, no MD_Done.
  - A following MUL 3×4 → 12.
- rst asserted mid-DIV, asynchronously between edges:
  - immediately IDLE, MD_Done = 0, MD_Result = 0;
  - after release, an op runs normally.
